// File: rtl/ysyx_22050710_axil_arbiter.sv
// Two-port round-robin arbiter sharing one AXI-lite master between instruction fetch and load/store.
// Request fields are captured at grant so the downstream transaction is immune to requester changes.
module ysyx_22050710_axil_arbiter #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  i_aclk,
    input  logic                  i_arsetn,

    input  logic                  i_if_valid,
    input  logic [ADDR_WIDTH-1:0] i_if_addr,
    output logic                  o_if_addr_ok,
    output logic                  o_if_data_ok,
    output logic [DATA_WIDTH-1:0] o_if_rdata,

    input  logic                  i_mem_valid,
    input  logic                  i_mem_ren,
    input  logic                  i_mem_wen,
    input  logic [ADDR_WIDTH-1:0] i_mem_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_wdata,
    input  logic [STRB_WIDTH-1:0] i_mem_size,
    output logic                  o_mem_addr_ok,
    output logic                  o_mem_data_ok,
    output logic [DATA_WIDTH-1:0] o_mem_rdata,

    output logic                  o_rw_valid,
    output logic                  o_rw_ren,
    output logic                  o_rw_wen,
    output logic [ADDR_WIDTH-1:0] o_rw_addr,
    output logic [DATA_WIDTH-1:0] o_rw_w_data,
    output logic [STRB_WIDTH-1:0] o_rw_size,
    input  logic                  i_rw_addr_ok,
    input  logic                  i_rw_data_ok,
    input  logic [DATA_WIDTH-1:0] i_data_read,

    output logic [1:0]            o_grant
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    state_t state;
    logic   owner;
    logic   last_owner;

    logic if_req_c;
    logic mem_req_c;
    logic pick_mem_c;
    logic addr_hs_c;
    logic data_hs_c;

    // A load/store request with neither direction set is not a real request.
    assign if_req_c   = i_if_valid;
    assign mem_req_c  = i_mem_valid & (i_mem_ren | i_mem_wen);
    assign pick_mem_c = mem_req_c & (~if_req_c | (last_owner == OWN_IF));

    // Handshakes only count while a transaction is in flight.
    assign addr_hs_c = (state == S_ADDR) & i_rw_addr_ok;
    assign data_hs_c = ((state == S_DATA) & i_rw_data_ok)
                     | ((state == S_ADDR) & i_rw_addr_ok & i_rw_data_ok);

    // Arbitration, request capture and transaction sequencing.
    always_ff @(posedge i_aclk or negedge i_arsetn) begin
        if (!i_arsetn) begin
            state       <= S_IDLE;
            owner       <= OWN_IF;
            last_owner  <= OWN_MEM;
            o_rw_addr   <= '0;
            o_rw_w_data <= '0;
            o_rw_size   <= '0;
            o_rw_ren    <= 1'b0;
            o_rw_wen    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (if_req_c | mem_req_c) begin
                        state <= S_ADDR;
                        if (pick_mem_c) begin
                            owner       <= OWN_MEM;
                            o_rw_addr   <= i_mem_addr;
                            o_rw_w_data <= i_mem_wdata;
                            o_rw_size   <= i_mem_size;
                            o_rw_ren    <= i_mem_ren;
                            o_rw_wen    <= i_mem_wen & ~i_mem_ren;
                        end else begin
                            owner       <= OWN_IF;
                            o_rw_addr   <= i_if_addr;
                            o_rw_w_data <= '0;
                            o_rw_size   <= '0;
                            o_rw_ren    <= 1'b1;
                            o_rw_wen    <= 1'b0;
                        end
                    end
                end
                S_ADDR: begin
                    if (i_rw_addr_ok) begin
                        if (i_rw_data_ok) begin
                            last_owner <= owner;
                            state      <= S_IDLE;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (i_rw_data_ok) begin
                        last_owner <= owner;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_rw_valid = (state == S_ADDR);
    assign o_grant    = (state == S_IDLE) ? 2'b00 :
                        (owner == OWN_MEM) ? 2'b10 : 2'b01;

    assign o_if_addr_ok  = addr_hs_c & (owner == OWN_IF);
    assign o_if_data_ok  = data_hs_c & (owner == OWN_IF);
    assign o_mem_addr_ok = addr_hs_c & (owner == OWN_MEM);
    assign o_mem_data_ok = data_hs_c & (owner == OWN_MEM);

    // Read data is broadcast; consumers qualify it with their data_ok.
    assign o_if_rdata  = i_data_read;
    assign o_mem_rdata = i_data_read;

endmodule
